// File: rtl/path_delay_tester.sv
// path_delay_tester: launch/capture controller for an inverter delay path.
// Each trial holds pathInput steady, toggles it once, registers pathResult
// exactly one clock later and scores the capture against the value a fast
// path of the given polarity would have produced. Runs alternate rising and
// falling launches because pathInput keeps its level between trials and runs.
module path_delay_tester #(
  parameter int TRIALS_W  = 16,
  parameter int SETTLE    = 2,
  parameter int INVERTING = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TRIALS_W-1:0] numTrials,
  output logic                pathInput,
  input  logic                pathResult,
  output logic                busy,
  output logic                done,
  output logic [TRIALS_W-1:0] passCount,
  output logic [TRIALS_W-1:0] failCount
);

  // Settle counter only has to reach SETTLE-1; keep it at least one bit wide.
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);
  localparam logic [TRIALS_W-1:0] TRIAL_ONE = TRIALS_W'(1);
  localparam logic INV = (INVERTING != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_EVAL
  } state_t;

  state_t              state_q, state_d;
  logic [SCW-1:0]      settleCnt_q, settleCnt_d;
  logic [TRIALS_W-1:0] trialIdx_q, trialIdx_d;
  logic [TRIALS_W-1:0] trialTotal_q, trialTotal_d;
  logic [TRIALS_W-1:0] passCount_q, passCount_d;
  logic [TRIALS_W-1:0] failCount_q, failCount_d;
  logic                pathInput_q, pathInput_d;
  logic                capture_q, capture_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                expected;
  logic                lastTrial;

  // The value a path shorter than one period delivers after the launch.
  assign expected  = pathInput_q ^ INV;
  assign lastTrial = ((trialIdx_q + TRIAL_ONE) == trialTotal_q);

  // Next-state logic: every register holds by default, done is a pulse.
  always_comb begin
    state_d      = state_q;
    settleCnt_d  = settleCnt_q;
    trialIdx_d   = trialIdx_q;
    trialTotal_d = trialTotal_q;
    passCount_d  = passCount_q;
    failCount_d  = failCount_q;
    pathInput_d  = pathInput_q;
    capture_d    = capture_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          passCount_d = '0;
          failCount_d = '0;
          if (numTrials != '0) begin
            trialTotal_d = numTrials;
            trialIdx_d   = '0;
            settleCnt_d  = '0;
            busy_d       = 1'b1;
            state_d      = ST_SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (settleCnt_q == SETTLE_LAST) begin
          settleCnt_d = '0;
          pathInput_d = ~pathInput_q;
          state_d     = ST_CAPTURE;
        end else begin
          settleCnt_d = settleCnt_q + SETTLE_ONE;
        end
      end

      ST_CAPTURE: begin
        capture_d = pathResult;
        state_d   = ST_EVAL;
      end

      ST_EVAL: begin
        if (capture_q == expected) begin
          passCount_d = passCount_q + TRIAL_ONE;
        end else begin
          failCount_d = failCount_q + TRIAL_ONE;
        end
        trialIdx_d = trialIdx_q + TRIAL_ONE;
        if (lastTrial) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any run without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settleCnt_q  <= '0;
      trialIdx_q   <= '0;
      trialTotal_q <= '0;
      passCount_q  <= '0;
      failCount_q  <= '0;
      pathInput_q  <= 1'b0;
      capture_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      trialIdx_q   <= trialIdx_d;
      trialTotal_q <= trialTotal_d;
      passCount_q  <= passCount_d;
      failCount_q  <= failCount_d;
      pathInput_q  <= pathInput_d;
      capture_q    <= capture_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pathInput = pathInput_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign passCount = passCount_q;
  assign failCount = failCount_q;

endmodule

// File: tb/tb_path_delay_tester.sv
// Bench for path_delay_tester: two instances (non-inverting, SETTLE=2 and
// inverting, SETTLE=3) driven by behavioural delay-path models. Expected
// completions and launch edges are queued when a run is started and compared
// when the DUT produces them.
module tb_path_delay_tester;

  localparam int W  = 16;
  localparam int S0 = 2;
  localparam int S1 = 3;

  typedef struct {
    int cyc;
    int pass;
    int fail;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [W-1:0] nt0, nt1;
  logic         pi0, pi1, pr0, pr1;
  logic         busy0, busy1, done0, done1;
  logic [W-1:0] passCount0, failCount0, passCount1, failCount1;

  logic [1:0]   mode0, mode1;
  logic         d1, d2;
  logic         prevPi0;
  logic         piExp0, piExp1;

  int vectors     = 0;
  int miscompares = 0;
  int cycCount    = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  int   launchQ[$];

  path_delay_tester #(.TRIALS_W(W), .SETTLE(S0), .INVERTING(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .numTrials(nt0),
    .pathInput(pi0), .pathResult(pr0), .busy(busy0), .done(done0),
    .passCount(passCount0), .failCount(failCount0)
  );

  path_delay_tester #(.TRIALS_W(W), .SETTLE(S1), .INVERTING(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .numTrials(nt1),
    .pathInput(pi1), .pathResult(pr1), .busy(busy1), .done(done1),
    .passCount(passCount1), .failCount(failCount1)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Edge counter used to timestamp launches and completions.
  always @(posedge clk) cycCount <= cycCount + 1;

  // Two-clock delay line modelling a path slower than the capture window.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= pi0;
      d2 <= d1;
    end
  end

  // Path models: 0 = zero-delay, 1 = two-clock delay, 2 = zero-delay inverted.
  always_comb begin
    pr0 = pi0;
    if (mode0 == 2'd1) pr0 = d2;
    else if (mode0 == 2'd2) pr0 = ~pi0;
    pr1 = (mode1 == 2'd2) ? ~pi1 : pi1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard for dut0: launch edges and completion results.
  always @(negedge clk) begin
    exp_t e;
    int   lc;
    if (rst) begin
      prevPi0 = pi0;
    end else begin
      if (pi0 !== prevPi0) begin
        if (launchQ.size() == 0) begin
          checkOutput("spuriousLaunch0", pi0, prevPi0);
        end else begin
          lc = launchQ.pop_front();
          checkOutput("launchCycle0", cycCount, lc);
        end
        prevPi0 = pi0;
      end
      if (done0) begin
        if (sb0.size() == 0) begin
          checkOutput("spuriousDone0", done0, 0);
        end else begin
          e = sb0.pop_front();
          checkOutput("doneCycle0", cycCount, e.cyc);
          checkOutput("passCount0", passCount0, e.pass);
          checkOutput("failCount0", failCount0, e.fail);
          checkOutput("busyAtDone0", busy0, 0);
        end
      end
    end
  end

  // Scoreboard for dut1: completion results only.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (sb1.size() == 0) begin
        checkOutput("spuriousDone1", done1, 0);
      end else begin
        e = sb1.pop_front();
        checkOutput("doneCycle1", cycCount, e.cyc);
        checkOutput("passCount1", passCount1, e.pass);
        checkOutput("failCount1", failCount1, e.fail);
        checkOutput("busyAtDone1", busy1, 0);
      end
    end
  end

  // Start a run and queue what it must produce.
  task automatic applyStimulus(input int which, input int n, input int expPass,
                               input int expFail, output int e0);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      start0 = 1'b1;
      nt0    = W'(n);
    end else begin
      start1 = 1'b1;
      nt1    = W'(n);
    end
    @(posedge clk);
    #1;
    e0     = cycCount;
    start0 = 1'b0;
    start1 = 1'b0;
    e.pass = expPass;
    e.fail = expFail;
    if (which == 0) begin
      nt0   = W'(n + 3);
      e.cyc = e0 + n * (S0 + 2);
      sb0.push_back(e);
      for (int k = 0; k < n; k++) launchQ.push_back(e0 + S0 + k * (S0 + 2));
      piExp0 = piExp0 ^ n[0];
      checkOutput("busyAtStart0", busy0, (n != 0) ? 1 : 0);
    end else begin
      nt1   = W'(n + 3);
      e.cyc = e0 + n * (S1 + 2);
      sb1.push_back(e);
      piExp1 = piExp1 ^ n[0];
      checkOutput("busyAtStart1", busy1, (n != 0) ? 1 : 0);
    end
  endtask

  // Wait for the scoreboard to drain, with a cycle budget.
  task automatic waitDone(input int which, input int bound);
    int c = 0;
    int left;
    left = (which == 0) ? sb0.size() : sb1.size();
    while (left != 0 && c < bound) begin
      @(posedge clk);
      c++;
      left = (which == 0) ? sb0.size() : sb1.size();
    end
    if (left != 0) checkOutput("timeout", left, 0);
    @(negedge clk);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic applyReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstPathInput", pi0, 0);
    checkOutput("rstBusy", busy0, 0);
    checkOutput("rstDone", done0, 0);
    checkOutput("rstPass", passCount0, 0);
    checkOutput("rstFail", failCount0, 0);
    sb0.delete();
    sb1.delete();
    launchQ.delete();
    piExp0 = 1'b0;
    piExp1 = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pathInputAfterRst", pi0, 0);
  endtask

  initial begin
    int e0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    nt0    = '0;
    nt1    = '0;
    mode0  = 2'd0;
    mode1  = 2'd2;
    piExp0 = 1'b0;
    piExp1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetPathInput", pi0, 0);
    checkOutput("resetBusy", busy0, 0);
    checkOutput("resetPass", passCount0, 0);
    checkOutput("resetFail", failCount0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] zero-delay path, 4 trials");
    applyStimulus(0, 4, 4, 0, e0);
    waitDone(0, 200);
    checkOutput("pathInputEnd", pi0, piExp0);

    $display("[TB] zero trials");
    applyStimulus(0, 0, 0, 0, e0);
    waitDone(0, 20);
    checkOutput("zeroBusy", busy0, 0);
    checkOutput("zeroPathInput", pi0, piExp0);

    $display("[TB] slow path, 3 trials");
    mode0 = 2'd1;
    repeat (3) @(negedge clk);
    applyStimulus(0, 3, 0, 3, e0);
    waitDone(0, 200);
    checkOutput("slowPathInputEnd", pi0, piExp0);
    mode0 = 2'd0;

    $display("[TB] start while busy, then reset mid-run");
    applyStimulus(0, 4, 4, 0, e0);
    while (cycCount < e0 + 5) @(negedge clk);
    start0 = 1'b1;
    nt0    = W'(1);
    @(negedge clk);
    start0 = 1'b0;
    while (cycCount < e0 + 9) @(negedge clk);
    checkOutput("midRunPass", passCount0, 2);
    checkOutput("midRunFail", failCount0, 0);
    checkOutput("midRunBusy", busy0, 1);
    applyReset();
    repeat (20) @(negedge clk);
    applyStimulus(0, 2, 2, 0, e0);
    waitDone(0, 200);

    $display("[TB] inverting path");
    mode1 = 2'd2;
    applyStimulus(1, 5, 5, 0, e0);
    waitDone(1, 200);
    checkOutput("invPathInputEnd", pi1, piExp1);
    mode1 = 2'd0;
    repeat (2) @(negedge clk);
    applyStimulus(1, 5, 0, 5, e0);
    waitDone(1, 200);

    repeat (4) @(negedge clk);
    checkOutput("leftover0", sb0.size(), 0);
    checkOutput("leftoverLaunch", launchQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/path_delay_tester.md
# path_delay_tester

Launch/capture controller for the inverter delay paths: it drives a path's `pathInput`, toggles it once per trial, samples `pathResult` one clock later and counts passes and fails against the expected polarity. It runs a programmed number of trials, alternating rising and falling launches. It sits between a delay-path instance and the measurement/readout logic, and flags paths whose propagation delay exceeds one clock period, such as a tampered or lengthened path.

## Interface

Parameters:
- `TRIALS_W`, default 16: width of `numTrials`, `passCount` and `failCount`.
- `SETTLE`, default 2: idle cycles (≥1) before each launch, with `pathInput` held stable so the path settles.
- `INVERTING`, default 0: path polarity. 0 means an even inverter count (`pathResult` = `pathInput`). 1 means an odd count.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a run; sampled only in IDLE.
- `numTrials`, input, `TRIALS_W`: trial count; latched when `start` is accepted.
- `pathInput`, output, 1: registered launch drive into the delay path.
- `pathResult`, input, 1: delay path output; asynchronous to `clk`.
- `busy`, output, 1: high while a run is in progress.
- `done`, output, 1: one-cycle pulse when a run completes.
- `passCount`, output, `TRIALS_W`: trials whose captured value matched the expected value.
- `failCount`, output, `TRIALS_W`: trials whose captured value mismatched.

## Operation

- **States:** IDLE, SETTLE, CAPTURE, EVAL.
- **IDLE:**
  - `start`=1 and `numTrials`≠0: latch `numTrials`, clear both counts, clear the trial index, set `busy`=1, go to SETTLE.
  - `start`=1 and `numTrials`=0: clear counts, pulse `done`, stay in IDLE, `busy` stays 0, `pathInput` unchanged.
- **SETTLE:** holds `pathInput` for `SETTLE` cycles. At the exit edge, `pathInput` toggles (the launch) and the FSM enters CAPTURE.
- **CAPTURE:** at the exit edge, `pathResult` is registered into the capture flop and the FSM enters EVAL.
- **EVAL:**
  - Expected value = `pathInput` XOR `INVERTING`.
  - Match increments `passCount`; mismatch increments `failCount`. Exactly one of the two increments per trial.
  - The trial index increments.
  - If the index equals the latched count, go to IDLE with `busy`=0 and `done`=1 for one cycle. Otherwise return to SETTLE.
- **Launch polarity:** `pathInput` is never reset by `start`. Its polarity carries over between runs, so successive launches alternate rise and fall.
- **Invariant:** `passCount` + `failCount` = latched `numTrials` at `done`. No overflow is possible.
- **Result hold:** counts hold their values after `done` until the next accepted `start`.
- **`start` while busy:** ignored. `numTrials` changes mid-run are ignored.
- **`rst` at any time:**
  - All outputs return to 0 and state returns to IDLE.
  - The in-progress run is discarded and no `done` is issued.

## Timing

- **Reset values:** `pathInput`=0, `busy`=0, `done`=0, `passCount`=0, `failCount`=0, capture flop=0, state=IDLE.
- **Start acceptance:** `start` is sampled at edge E0. `busy` is 1 from E0.
- **Per-trial edges**, for trial k with k = 0..N−1:
  - Launch (toggle): E0 + `SETTLE` + k·(`SETTLE`+2).
  - Capture: launch + 1.
  - Count update: launch + 2.
- **Completion:** the final count update is at edge E0 + N·(`SETTLE`+2). `done`=1 and `busy`=0 from that edge for exactly one cycle. The counts are final in the same cycle.
- **Zero-trial run:** `done`=1 from E0 for one cycle.
- **Capture window:** exactly one clock period. A path delay below one period (minus setup) passes; above one period it fails.
- **Metastability:** the capture flop is the only point where `pathResult` is sampled. Its metastability is accepted as part of the measurement.
- **Back-to-back runs:** a new `start` may be accepted in the cycle `done` is high, since the FSM is already in IDLE.

## Test plan

- **Reset:** assert `rst` mid-stream, asynchronously, between clock edges → all outputs 0 immediately. `pathInput`=0 after release.
- **Zero-delay path:** bench model `pathResult`=`pathInput`; `SETTLE`=2, `numTrials`=4 → `pathInput` toggles at E0+2, +6, +10, +14. `done` at E0+16 with `passCount`=4, `failCount`=0. `pathInput` ends at 0.
- **Slow path:** model `pathResult` = `pathInput` delayed by 2 clocks, `numTrials`=3 → `failCount`=3, `passCount`=0, `done` at E0+12.
- **Zero trials:** `numTrials`=0 → `done` pulses from E0. Counts 0, `busy` never 1, `pathInput` unchanged.
- **Start while busy, then reset:** pulse `start` during trial 1 → ignored, counts unaffected. Assert `rst` during trial 2 → counts 0, no `done`. A new run with `numTrials`=2 then completes with `passCount`=2.
- **Inverting path:** `INVERTING`=1 with an inverted zero-delay model, `numTrials`=5 → `passCount`=5. With a non-inverted model → `failCount`=5.
